spine_leaf_port: RTL and testbench

Spine-side endpoint for one leaf-router spine link: the far end of a router's `spineN_out_*` / `spineN_in_*` pins. It accepts unthrottled valid-only flits from the leaf router, buffers them, and presents them to the spine crossbar with a valid/ready handshake plus the extracted destination address. In the reverse direction it accepts crossbar flits with valid/ready and paces them onto the leaf's valid-only input with a configurable inter-flit gap. It instantiates once per leaf link inside the spine switch.

---
 rtl/spine_pkg.sv | 15 +
 rtl/spine_sync_fifo.sv | 63 ++++++
 rtl/spine_leaf_port.sv | 195 +++++++++++++++++++
 tb/tb_spine_leaf_port.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
// Shared constants and types for the spine-side leaf link endpoint.
package spine_pkg;

  localparam int DEST_MSB = 15;
  localparam int DEST_LSB = 10;
  localparam int DEST_W   = 6;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;

endpackage

// File: rtl/spine_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module spine_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en;
  logic             rd_en;

  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/spine_leaf_port.sv
// Spine-side endpoint of one leaf-router link.
// Ingress: valid-only leaf flits are buffered and offered to the crossbar
// with valid/ready. Egress: crossbar flits are buffered and paced onto the
// leaf's valid-only input with TX_GAP idle cycles between strobes.
// Define SPINE_PORT_STATS_EN to build the drop/tx/rx statistics counters;
// otherwise those ports are tied to zero.
module spine_leaf_port
  import spine_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 4,
  parameter int TX_GAP    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] leaf_in_data,
  input  logic              leaf_in_valid,
  output logic [DWIDTH-1:0] leaf_out_data,
  output logic              leaf_out_valid,
  output logic [DEST_W-1:0] leaf_out_dest_addr,
  output logic [DWIDTH-1:0] sw_out_data,
  output logic [DEST_W-1:0] sw_out_dest_addr,
  output logic              sw_out_valid,
  input  logic              sw_out_ready,
  input  logic [DWIDTH-1:0] sw_in_data,
  input  logic              sw_in_valid,
  output logic              sw_in_ready,
  output logic              in_full,
  output logic              in_empty,
  output logic              out_full,
  output logic              out_empty,
  output logic [STAT_W-1:0] drop_count,
  output logic [STAT_W-1:0] tx_count,
  output logic [STAT_W-1:0] rx_count
);

  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [OUT_CW-1:0] OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);
  localparam logic [3:0] GAP_LOAD = (TX_GAP > 0) ? 4'(TX_GAP - 1) : 4'd0;

  logic [DWIDTH-1:0] in_head;
  logic [IN_CW-1:0]  in_count;
  logic              in_pop;

  logic [DWIDTH-1:0] out_head;
  logic [OUT_CW-1:0] out_count;
  logic              out_push;
  logic              out_pop;

  tx_state_t state;
  tx_state_t state_n;
  logic [3:0] gap_cnt;
  logic [3:0] gap_n;

  // Ingress path: leaf flits toward the crossbar
  assign sw_out_valid     = (in_count != '0);
  assign in_pop           = sw_out_valid && sw_out_ready;
  assign sw_out_data      = sw_out_valid ? in_head : '0;
  assign sw_out_dest_addr = sw_out_data[DEST_MSB:DEST_LSB];

  spine_sync_fifo #(
    .DEPTH(IN_DEPTH),
    .WIDTH(DWIDTH)
  ) u_in_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (leaf_in_valid),
    .push_data(leaf_in_data),
    .pop      (in_pop),
    .pop_data (in_head),
    .full     (in_full),
    .empty    (in_empty),
    .count    (in_count)
  );

  // Egress path: crossbar flits toward the leaf
  assign sw_in_ready = (out_count != OUT_FULL_CNT);
  assign out_push    = sw_in_valid && sw_in_ready;

  spine_sync_fifo #(
    .DEPTH(OUT_DEPTH),
    .WIDTH(DWIDTH)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (out_push),
    .push_data(sw_in_data),
    .pop      (out_pop),
    .pop_data (out_head),
    .full     (out_full),
    .empty    (out_empty),
    .count    (out_count)
  );

  // TX pacing: decide next state, gap countdown and when to pop the egress FIFO
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    out_pop = 1'b0;
    case (state)
      IDLE: begin
        if (!out_empty) begin
          out_pop = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (TX_GAP == 0) begin
          if (!out_empty) begin
            out_pop = 1'b1;
            state_n = SEND;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = GAP;
          gap_n   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          if (!out_empty) begin
            out_pop = 1'b1;
            state_n = SEND;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // TX state, gap counter and the registered leaf output flit
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      gap_cnt            <= 4'd0;
      leaf_out_data      <= '0;
      leaf_out_dest_addr <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      if (out_pop) begin
        leaf_out_data      <= out_head;
        leaf_out_dest_addr <= out_head[DEST_MSB:DEST_LSB];
      end
    end
  end

  assign leaf_out_valid = (state == SEND);

`ifdef SPINE_PORT_STATS_EN
  localparam logic [IN_CW-1:0] IN_FULL_CNT = IN_CW'(IN_DEPTH);

  logic              in_drop;
  logic [STAT_W-1:0] drop_q;
  logic [STAT_W-1:0] tx_q;
  logic [STAT_W-1:0] rx_q;

  assign in_drop = leaf_in_valid && (in_count == IN_FULL_CNT) && !in_pop;

  // Link statistics: drops saturate, tx/rx wrap; rx counts dropped flits too
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      if (in_drop && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
      if (leaf_out_valid) begin
        tx_q <= tx_q + 1'b1;
      end
      if (leaf_in_valid) begin
        rx_q <= rx_q + 1'b1;
      end
    end
  end

  assign drop_count = drop_q;
  assign tx_count   = tx_q;
  assign rx_count   = rx_q;
`else
  assign drop_count = '0;
  assign tx_count   = '0;
  assign rx_count   = '0;
`endif

endmodule

// File: tb/tb_spine_leaf_port.sv
// Scoreboard bench for spine_leaf_port: stimulus pushes expected flits into
// queues, independent monitors pop and compare when the DUT presents them.
// Instance dut uses TX_GAP=2, instance dut0 uses TX_GAP=0.
module tb_spine_leaf_port;

  typedef struct {
    logic [15:0] data;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] leaf_in_data;
  logic        leaf_in_valid;
  logic [15:0] leaf_out_data;
  logic        leaf_out_valid;
  logic [5:0]  leaf_out_dest_addr;
  logic [15:0] sw_out_data;
  logic [5:0]  sw_out_dest_addr;
  logic        sw_out_valid;
  logic        sw_out_ready;
  logic [15:0] sw_in_data;
  logic        sw_in_valid;
  logic        sw_in_ready;
  logic        in_full, in_empty, out_full, out_empty;
  logic [15:0] drop_count, tx_count, rx_count;

  logic [15:0] b_leaf_in_data;
  logic        b_leaf_in_valid;
  logic [15:0] b_leaf_out_data;
  logic        b_leaf_out_valid;
  logic [5:0]  b_leaf_out_dest_addr;
  logic [15:0] b_sw_out_data;
  logic [5:0]  b_sw_out_dest_addr;
  logic        b_sw_out_valid;
  logic        b_sw_out_ready;
  logic [15:0] b_sw_in_data;
  logic        b_sw_in_valid;
  logic        b_sw_in_ready;
  logic        b_in_full, b_in_empty, b_out_full, b_out_empty;
  logic [15:0] b_drop_count, b_tx_count, b_rx_count;

  logic [15:0] ing_q[$];
  exp_t        egr_q[$];
  exp_t        egr_b_q[$];
  logic [15:0] ing_e;
  exp_t        egr_e;
  exp_t        egr_b_e;

  spine_leaf_port #(.DWIDTH(16), .IN_DEPTH(8), .OUT_DEPTH(4), .TX_GAP(2)) dut (
    .clk(clk), .reset(reset),
    .leaf_in_data(leaf_in_data), .leaf_in_valid(leaf_in_valid),
    .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
    .leaf_out_dest_addr(leaf_out_dest_addr),
    .sw_out_data(sw_out_data), .sw_out_dest_addr(sw_out_dest_addr),
    .sw_out_valid(sw_out_valid), .sw_out_ready(sw_out_ready),
    .sw_in_data(sw_in_data), .sw_in_valid(sw_in_valid), .sw_in_ready(sw_in_ready),
    .in_full(in_full), .in_empty(in_empty), .out_full(out_full), .out_empty(out_empty),
    .drop_count(drop_count), .tx_count(tx_count), .rx_count(rx_count)
  );

  spine_leaf_port #(.DWIDTH(16), .IN_DEPTH(8), .OUT_DEPTH(4), .TX_GAP(0)) dut0 (
    .clk(clk), .reset(reset),
    .leaf_in_data(b_leaf_in_data), .leaf_in_valid(b_leaf_in_valid),
    .leaf_out_data(b_leaf_out_data), .leaf_out_valid(b_leaf_out_valid),
    .leaf_out_dest_addr(b_leaf_out_dest_addr),
    .sw_out_data(b_sw_out_data), .sw_out_dest_addr(b_sw_out_dest_addr),
    .sw_out_valid(b_sw_out_valid), .sw_out_ready(b_sw_out_ready),
    .sw_in_data(b_sw_in_data), .sw_in_valid(b_sw_in_valid), .sw_in_ready(b_sw_in_ready),
    .in_full(b_in_full), .in_empty(b_in_empty), .out_full(b_out_full), .out_empty(b_out_empty),
    .drop_count(b_drop_count), .tx_count(b_tx_count), .rx_count(b_rx_count)
  );

  // Free-running clock and cycle counter used for latency checks
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] stat(input int v);
`ifdef SPINE_PORT_STATS_EN
    return 32'(v);
`else
    return 32'(0 * v);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lv, input logic [15:0] ld, input logic rdy,
                               input logic sv, input logic [15:0] sd);
    leaf_in_valid = lv;
    leaf_in_data  = ld;
    sw_out_ready  = rdy;
    sw_in_valid   = sv;
    sw_in_data    = sd;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Ingress monitor: every crossbar handshake must match the next expected flit
  always @(negedge clk) begin
    if (sw_out_valid && sw_out_ready) begin
      if (ing_q.size() == 0) begin
        checkOutput("ingress_unexpected", 32'(sw_out_valid), 32'd0);
      end else begin
        ing_e = ing_q.pop_front();
        checkOutput("ingress_data", 32'(sw_out_data), 32'(ing_e));
        checkOutput("ingress_dest", 32'(sw_out_dest_addr), 32'(ing_e[15:10]));
      end
    end
  end

  // Egress monitor for the TX_GAP=2 instance: data, dest and arrival cycle
  always @(negedge clk) begin
    if (leaf_out_valid) begin
      if (egr_q.size() == 0) begin
        checkOutput("egress_unexpected", 32'(leaf_out_valid), 32'd0);
      end else begin
        egr_e = egr_q.pop_front();
        checkOutput("egress_data", 32'(leaf_out_data), 32'(egr_e.data));
        checkOutput("egress_dest", 32'(leaf_out_dest_addr), 32'(egr_e.data[15:10]));
        checkOutput("egress_cycle", 32'(cyc), 32'(egr_e.at));
      end
    end
  end

  // Egress monitor for the TX_GAP=0 instance
  always @(negedge clk) begin
    if (b_leaf_out_valid) begin
      if (egr_b_q.size() == 0) begin
        checkOutput("b2b_unexpected", 32'(b_leaf_out_valid), 32'd0);
      end else begin
        egr_b_e = egr_b_q.pop_front();
        checkOutput("b2b_data", 32'(b_leaf_out_data), 32'(egr_b_e.data));
        checkOutput("b2b_cycle", 32'(cyc), 32'(egr_b_e.at));
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    exp_t e;
    logic [15:0] d;

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    b_leaf_in_valid = 1'b0;
    b_leaf_in_data  = 16'h0;
    b_sw_out_ready  = 1'b0;
    b_sw_in_valid   = 1'b0;
    b_sw_in_data    = 16'h0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_sw_out_valid", 32'(sw_out_valid), 32'd0);
    checkOutput("rst_sw_out_data", 32'(sw_out_data), 32'd0);
    checkOutput("rst_in_empty", 32'(in_empty), 32'd1);
    checkOutput("rst_in_full", 32'(in_full), 32'd0);
    checkOutput("rst_out_empty", 32'(out_empty), 32'd1);
    checkOutput("rst_out_full", 32'(out_full), 32'd0);
    checkOutput("rst_sw_in_ready", 32'(sw_in_ready), 32'd1);
    checkOutput("rst_leaf_out_valid", 32'(leaf_out_valid), 32'd0);
    checkOutput("rst_leaf_out_data", 32'(leaf_out_data), 32'd0);
    checkOutput("rst_counts", 32'({drop_count, tx_count | rx_count}), 32'd0);

    // Ingress passthrough: 0x8C01 -> dest 0x23 one cycle later
    applyStimulus(1'b1, 16'h8C01, 1'b1, 1'b0, 16'h0);
    ing_q.push_back(16'h8C01);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    checkOutput("t1_in_empty_busy", 32'(in_empty), 32'd0);
    tick();
    checkOutput("t1_in_empty_after", 32'(in_empty), 32'd1);
    checkOutput("t1_rx_count", 32'(rx_count), stat(1));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    doReset();

    // Ingress overflow: 10 flits into depth 8 with no ready
    for (int i = 0; i < 10; i++) begin
      d = {6'(i + 5), 10'(16'h2A0 + i)};
      applyStimulus(1'b1, d, 1'b0, 1'b0, 16'h0);
      if (i < 8) ing_q.push_back(d);
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("t2_in_full", 32'(in_full), 32'd1);
    checkOutput("t2_drop_count", 32'(drop_count), stat(2));
    checkOutput("t2_rx_count", 32'(rx_count), stat(10));

    // Full FIFO with simultaneous pop: write accepted, no drop, still full
    applyStimulus(1'b1, 16'hF00B, 1'b1, 1'b0, 16'h0);
    ing_q.push_back(16'hF00B);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("t3_in_full", 32'(in_full), 32'd1);
    checkOutput("t3_drop_count", 32'(drop_count), stat(2));
    checkOutput("t3_rx_count", 32'(rx_count), stat(11));
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    repeat (8) tick();
    checkOutput("t3_drained_empty", 32'(in_empty), 32'd1);
    checkOutput("t3_ingress_left", 32'(ing_q.size()), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    doReset();

    // Egress pacing with TX_GAP=2: six flits, one strobe every 3 cycles
    k = cyc;
    for (int i = 0; i < 6; i++) begin
      d = {6'(i + 1), 10'(16'h155 + i)};
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, d);
      e.data = d;
      e.at   = k + 2 + 3 * i;
      egr_q.push_back(e);
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("t4_sw_in_ready_full", 32'(sw_in_ready), 32'd0);
    checkOutput("t4_out_full", 32'(out_full), 32'd1);
    repeat (14) tick();
    checkOutput("t4_tx_count", 32'(tx_count), stat(6));
    checkOutput("t4_out_empty", 32'(out_empty), 32'd1);
    checkOutput("t4_egress_left", 32'(egr_q.size()), 32'd0);

    // Back-to-back egress with TX_GAP=0: four consecutive strobes
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      d = 16'hA000 + 16'(i * 16'h0411);
      b_sw_in_valid = 1'b1;
      b_sw_in_data  = d;
      e.data = d;
      e.at   = k + 2 + i;
      egr_b_q.push_back(e);
      tick();
    end
    b_sw_in_valid = 1'b0;
    repeat (6) tick();
    checkOutput("t5_tx_count", 32'(b_tx_count), stat(4));
    checkOutput("t5_egress_left", 32'(egr_b_q.size()), 32'd0);
    doReset();

    // Reset during GAP with queued traffic in both directions
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      d = 16'h3300 + 16'(i);
      applyStimulus(1'b1, d, 1'b0, 1'b1, ~d);
      if (i == 0) begin
        e.data = ~d;
        e.at   = k + 2;
        egr_q.push_back(e);
      end
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6_pre_out_empty", 32'(out_empty), 32'd0);
    checkOutput("t6_pre_in_empty", 32'(in_empty), 32'd0);
    checkOutput("t6_pre_in_gap", 32'(leaf_out_valid), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("t6_leaf_out_valid", 32'(leaf_out_valid), 32'd0);
    checkOutput("t6_leaf_out_data", 32'({leaf_out_data, 10'd0, leaf_out_dest_addr}), 32'd0);
    checkOutput("t6_sw_out", 32'({sw_out_data, 10'd0, sw_out_dest_addr}), 32'd0);
    checkOutput("t6_sw_out_valid", 32'(sw_out_valid), 32'd0);
    checkOutput("t6_in_empty", 32'(in_empty), 32'd1);
    checkOutput("t6_out_empty", 32'(out_empty), 32'd1);
    checkOutput("t6_sw_in_ready", 32'(sw_in_ready), 32'd1);
    checkOutput("t6_counts", 32'({drop_count, tx_count | rx_count}), 32'd0);
    reset = 1'b0;
    repeat (12) tick();
    checkOutput("t6_egress_left", 32'(egr_q.size()), 32'd0);
    checkOutput("t6_out_empty_later", 32'(out_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
